// File: rtl/mips_defs.sv
// Shared MIPS definitions for the EX-stage multiply/divide unit.
// Holds op encodings, default latencies and the FSM state encoding.
package mips_defs;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_t;

  function automatic logic md_is_valid(input logic [2:0] op);
    return (op != MD_NONE) && (op != 3'd7);
  endfunction

  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_calc.sv
// Combinational MULT/MULTU/DIV/DIVU datapath producing {hi, lo} and a divide-by-zero flag.
// Zero latency; no flow control.
module muldiv_calc
  import mips_defs::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_res_hi,
  output logic [31:0] o_res_lo,
  output logic        o_div_by_zero
);

  logic        w_b_zero;
  logic        w_ovf;
  logic [31:0] w_den;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_quot_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_quot_u;
  logic [31:0] w_rem_u;

  assign w_b_zero = (i_b == 32'd0);
  assign w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
  // The divider never sees zero or the INT_MIN/-1 pair; those results are patched below.
  assign w_den    = (w_b_zero || w_ovf) ? 32'd1 : i_b;

  assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};
  assign w_quot_s = $signed(i_a) / $signed(w_den);
  assign w_rem_s  = $signed(i_a) % $signed(w_den);
  assign w_quot_u = i_a / w_den;
  assign w_rem_u  = i_a % w_den;

  always_comb begin
    o_res_hi      = 32'd0;
    o_res_lo      = 32'd0;
    o_div_by_zero = 1'b0;
    case (i_op)
      MD_MULT:  {o_res_hi, o_res_lo} = w_prod_s;
      MD_MULTU: {o_res_hi, o_res_lo} = w_prod_u;
      MD_DIV: begin
        o_div_by_zero = w_b_zero;
        if (w_ovf) begin
          o_res_lo = 32'h8000_0000;
          o_res_hi = 32'd0;
        end else begin
          o_res_lo = w_quot_s;
          o_res_hi = w_rem_s;
        end
      end
      MD_DIVU: begin
        o_div_by_zero = w_b_zero;
        o_res_lo      = w_quot_u;
        o_res_hi      = w_rem_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative mul/div unit owning HI/LO; results commit MULT_CYCLES/DIV_CYCLES after accept,
// MTHI/MTLO in one cycle. stall_req holds the pipeline while busy or a HI/LO op is presented.
module ex_muldiv_unit
  import mips_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);

  md_state_t          r_state;
  md_state_t          w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_pend_hi;
  logic [31:0]        r_pend_lo;
  logic               r_no_write;
  logic               w_accept;
  logic               w_accept_md;
  logic               w_commit;
  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;
  logic               w_div_by_zero;

  muldiv_calc u_calc (
    .i_op          (op),
    .i_a           (a),
    .i_b           (b),
    .o_res_hi      (w_res_hi),
    .o_res_lo      (w_res_lo),
    .o_div_by_zero (w_div_by_zero)
  );

  assign busy      = (r_state == MD_RUN);
  assign stall_req = busy | (start & md_is_valid(op));
  assign hi        = r_hi;
  assign lo        = r_lo;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_accept_md = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      MD_IDLE: begin
        w_accept    = start & ~flush & md_is_valid(op);
        w_accept_md = w_accept & md_is_arith(op);
        if (w_accept_md) begin
          w_state_nxt = MD_RUN;
          w_cnt_nxt   = ((op == MD_MULT) || (op == MD_MULTU)) ? CNT_W'(MULT_CYCLES)
                                                               : CNT_W'(DIV_CYCLES);
        end
      end
      MD_RUN: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_commit    = 1'b1;
          w_state_nxt = MD_IDLE;
        end
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= MD_IDLE;
      r_cnt      <= '0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_pend_hi  <= 32'd0;
      r_pend_lo  <= 32'd0;
      r_no_write <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept_md) begin
        r_pend_hi  <= w_res_hi;
        r_pend_lo  <= w_res_lo;
        r_no_write <= w_div_by_zero;
      end
      // Commit only happens in RUN and accept only in IDLE, so these never collide.
      if (w_commit && !r_no_write) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
      if (w_accept && (op == MD_MTHI)) r_hi <= a;
      if (w_accept && (op == MD_MTLO)) r_lo <= a;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit with default latencies (MULT 5, DIV 10).
module tb_ex_muldiv_unit;

  logic        Clk;
  logic        Reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  ex_muldiv_unit dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one arithmetic op for a single cycle, checks n busy cycles, then the committed result.
  task automatic run_md(input string tag, input logic [2:0] t_op, input logic [31:0] t_a,
                        input logic [31:0] t_b, input int n, input logic [31:0] old_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start = 1'b1; op = t_op; a = t_a; b = t_b;
    #1;
    chk({tag, "_stall_req_at_start"}, {31'd0, stall_req}, 32'd1);
    tick();
    start = 1'b0; op = 3'd0;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
      if (i == n - 1) chk({tag, "_lo_before_commit"}, lo, old_lo);
      tick();
    end
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; flush = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_stall", {31'd0, stall_req}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    // op 7 is not a HI/LO op and must not request a stall
    start = 1'b1; op = 3'd7;
    #1;
    chk("op7_stall", {31'd0, stall_req}, 32'd0);
    start = 1'b0; op = 3'd0;

    run_md("mult",  3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    // Back-to-back: issued in the very cycle busy fell
    run_md("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFA, 32'h0000_0002, 32'hFFFF_FFFA);
    run_md("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'hFFFF_FFFD, 32'd0, 32'h8000_0000);

    // MTLO then MTHI on consecutive cycles
    start = 1'b1; op = 3'd6; a = 32'h1234_5678;
    tick();
    chk("mtlo_lo", lo, 32'h1234_5678);
    chk("mtlo_hi", hi, 32'd0);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    op = 3'd5; a = 32'hCAFE_BABE;
    tick();
    chk("mthi_hi", hi, 32'hCAFE_BABE);
    chk("mthi_lo", lo, 32'h1234_5678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);

    // Preload HI/LO, then DIVU by zero must leave them untouched
    op = 3'd5; a = 32'h11;
    tick();
    op = 3'd6; a = 32'h22;
    tick();
    start = 1'b0; op = 3'd0;
    chk("preload_hi", hi, 32'h11);
    chk("preload_lo", lo, 32'h22);
    run_md("divu_zero", 3'd4, 32'd1234, 32'd0, 10, 32'h22, 32'h11, 32'h22);

    // Flushed MULT is not accepted
    start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd3; flush = 1'b1;
    tick();
    start = 1'b0; op = 3'd0; flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("flush_hi", hi, 32'h11);
    chk("flush_lo", lo, 32'h22);

    // Start pulse in busy cycle 3 of a DIV is ignored
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0; op = 3'd0;
    tick(); tick();
    start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd5;
    chk("ign_stall", {31'd0, stall_req}, 32'd1);
    tick();
    start = 1'b0; op = 3'd0;
    for (int i = 3; i < 10; i++) begin
      chk("ign_busy_run", {31'd0, busy}, 32'd1);
      tick();
    end
    chk("ign_busy_done", {31'd0, busy}, 32'd0);
    chk("ign_div_hi", hi, 32'd2);
    chk("ign_div_lo", lo, 32'd14);
    tick();
    chk("ign_no_mult", {31'd0, busy}, 32'd0);

    // Reset in busy cycle 4 of a MULT discards the result
    start = 1'b1; op = 3'd1; a = 32'd7; b = 32'd9;
    tick();
    start = 1'b0; op = 3'd0;
    tick(); tick(); tick();
    chk("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    tick(); tick(); tick(); tick(); tick();
    chk("rst_after_busy", {31'd0, busy}, 32'd0);
    chk("rst_after_hi", hi, 32'd0);
    chk("rst_after_lo", lo, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage. It owns the architectural HI/LO registers and drives the `hi`/`lo` values that the EX/MEM pipeline register latches. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX-stage instruction and models multi-cycle latency with a countdown. While an operation is in flight it raises a stall request to the hazard unit.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU (≥1).
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU (≥1).

Ports:
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `start`  in  1  EX instruction is a HI/LO-writing op; qualifies `op`.
- `op`  in  3  1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO; 0 and 7 are ignored.
- `a`  in  32  rs operand (forwarded).
- `b`  in  32  rt operand (forwarded).
- `flush`  in  1  EX instruction is being squashed (exception or eret in a later stage).
- `busy`  out  1  operation in flight.
- `stall_req`  out  1  combinational: `busy | (start & op∈{1..6})`; the hazard unit stalls MULT/DIV/MFHI/MFLO/MTHI/MTLO in EX when this is high.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- Two states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1; a down-counter `cnt` holds the remaining cycles.
- Accept condition: `start & ~flush & ~busy & op∈{1..6}`. Any start arriving while `busy` is high is ignored; the hazard unit guarantees this never happens legitimately.
- MULT/MULTU:
  - Compute the 64-bit product at accept (signed or unsigned respectively).
  - Latch `{pend_hi, pend_lo}` = {product[63:32], product[31:0]}.
  - `cnt`←MULT_CYCLES, go to RUN.
- DIV/DIVU:
  - `pend_lo`=quotient, truncated toward zero; `pend_hi`=remainder, sign of the dividend (signed).
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - `cnt`←DIV_CYCLES, go to RUN.
  - Divide by zero (`b`==0): still enter RUN for DIV_CYCLES, but hi/lo stay unchanged at commit (do-not-write flag).
- MTHI/MTLO: `hi`←`a` (or `lo`←`a`) at the accepting edge. No RUN, `busy` stays 0.
- RUN:
  - Each edge, `cnt`←`cnt`−1.
  - On the edge where `cnt`==1, commit pending values to hi/lo (unless do-not-write) and return to IDLE.
- `flush` does not affect an operation already in RUN; it is already committed architecturally.
- `Reset` (any state, including mid-RUN): state IDLE, `cnt`=0, `busy`=0, `hi`=0, `lo`=0, pending registers=0, do-not-write=0. The in-flight result is discarded.

## Timing
- Accept at edge E:
  - `busy` is high in cycles E+1 … E+N, with N=MULT_CYCLES or DIV_CYCLES.
  - New hi/lo are visible in cycle E+N+1, the same cycle `busy` falls.
- MFHI/MFLO in EX stalls while `stall_req` is high and reads the correct value in cycle E+N+1. The EX/MEM register therefore never captures a stale hi/lo.
- MTHI/MTLO accepted at edge E: new value visible in cycle E+1.
- Back-to-back: a second MULT presented in cycle E+N+1 (`busy`=0) is accepted at the next edge. There is no dead cycle beyond the stall.
- `stall_req` is combinational from `start`/`op`; `busy`, `hi` and `lo` are registered.

## Structure
- Shared package `mips_defs` holds:
  - op encodings `MD_NONE`, `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`;
  - the default latency constants;
  - the state encoding `MD_IDLE` / `MD_RUN`.
- One natural sub-module: `muldiv_calc`. It is combinational and maps `op`, `a`, `b` to {res_hi, res_lo, div_by_zero}. The top level keeps the FSM, counter, pending registers and HI/LO.

## Test plan
- MULT a=0xFFFFFFFE (−2), b=3, start one cycle: `busy` high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (−7), b=2: `busy` high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- MTLO a=0x12345678 then MTHI a=0xCAFEBABE on consecutive cycles: lo updated in cycle+1, hi in cycle+2, `busy` never high.
- DIVU b=0 with hi/lo preloaded to 0x11/0x22: `busy` high 10 cycles, then hi/lo remain 0x11/0x22.
- MULT with `flush`=1 in the start cycle: not accepted, `busy` stays 0, hi/lo unchanged. A start pulse at busy cycle 3 of an earlier DIV is ignored and the DIV result commits normally.
- `Reset` asserted at busy cycle 4 of a MULT: next cycle `busy`=0, hi=lo=0, and no commit occurs afterwards.
